// File: rtl/clkctl_pkg.sv
// Shared definitions for the clock switch controller: state encoding,
// default sequence lengths and the shared-counter width helper.
package clkctl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_QUIESCE  = 3'd1,
    ST_SWITCH   = 3'd2,
    ST_PLLRST   = 3'd3,
    ST_WAITLOCK = 3'd4,
    ST_SETTLE   = 3'd5,
    ST_RUN      = 3'd6
  } clk_state_e;

  localparam int DEF_NUM_SRC     = 2;
  localparam int DEF_QUIESCE_CYC = 16;
  localparam int DEF_PLL_RST_CYC = 8;
  localparam int DEF_SETTLE_CYC  = 256;
  localparam int DEF_LOCK_TO_CYC = 65535;

  // Width of one down-counter able to hold the largest of the four counts.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/clock_switch_ctrl_sync2.sv
// Two-flop synchronizer for asynchronous status inputs (PLL lock and
// similar). Output is delayed by two clock cycles; resets to zero.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q, meta_d;
  logic [W-1:0] sync_q, sync_d;

  // Next values: first stage captures the raw input, second stage the first.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronizer flops, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/clock_switch_ctrl.sv
// Glitch-safe clock source switch sequencer. Holds the downstream domain in
// reset, changes the BUFGMUX select, pulses the PLL reset, waits for lock and
// a settle period, then releases the downstream reset.
// Optional feature: define CLKSW_TIMEOUT_EN to enable the lock timeout with
// retry and the sticky lock_err flag; otherwise WAITLOCK waits forever.
module clock_switch_ctrl
  import clkctl_pkg::*;
#(
  parameter int NUM_SRC     = DEF_NUM_SRC,
  parameter int SEL_W       = $clog2(NUM_SRC),
  parameter int QUIESCE_CYC = DEF_QUIESCE_CYC,
  parameter int PLL_RST_CYC = DEF_PLL_RST_CYC,
  parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
  parameter int LOCK_TO_CYC = DEF_LOCK_TO_CYC
) (
  input  logic             src_clock,
  input  logic             rst_n,
  input  logic [SEL_W-1:0] req_sel,
  input  logic             locked,
  output logic [SEL_W-1:0] mux_sel,
  output logic             pll_rst,
  output logic             sys_rst_n,
  output logic             busy,
  output logic             lock_err
);

  localparam int CNT_W = cnt_width(QUIESCE_CYC, PLL_RST_CYC, SETTLE_CYC, LOCK_TO_CYC);

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] LD_QUIESCE = CNT_W'(QUIESCE_CYC - 1);
  localparam logic [CNT_W-1:0] LD_PLLRST  = CNT_W'(PLL_RST_CYC - 1);
  localparam logic [CNT_W-1:0] LD_SETTLE  = CNT_W'(SETTLE_CYC - 1);
  // The WAITLOCK cycle that first sees lock already counts as a locked cycle.
  localparam logic [CNT_W-1:0] LD_SETTLE1 = CNT_W'(SETTLE_CYC - 2);
`ifdef CLKSW_TIMEOUT_EN
  localparam logic [CNT_W-1:0] LD_LOCK_TO = CNT_W'(LOCK_TO_CYC);
`endif

  clk_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] mux_sel_q, mux_sel_d;
  logic [SEL_W-1:0] req_q, req_d;
  logic             locked_s;
  logic             req_valid;
`ifdef CLKSW_TIMEOUT_EN
  logic             lock_err_q, lock_err_d;
`endif

  sync2 #(.W(1)) u_lock_sync (
    .clk   (src_clock),
    .rst_n (rst_n),
    .d     (locked),
    .q     (locked_s)
  );

  // Requests outside the populated source range never start a sequence.
  assign req_valid = ({1'b0, req_q} < (SEL_W + 1)'(NUM_SRC));

  // Next-state, counter and select update for the switch sequence.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mux_sel_d = mux_sel_q;
    req_d     = req_sel;
`ifdef CLKSW_TIMEOUT_EN
    lock_err_d = lock_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        state_d = ST_QUIESCE;
        cnt_d   = LD_QUIESCE;
      end
      ST_QUIESCE: begin
        if (cnt_q == '0) begin
          // New select is registered here so it is stable at the BUFGMUX
          // for the whole SWITCH cycle; later requests wait for RUN.
          if (req_valid) mux_sel_d = req_q;
          state_d = ST_SWITCH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_SWITCH: begin
        state_d = ST_PLLRST;
        cnt_d   = LD_PLLRST;
      end
      ST_PLLRST: begin
        if (cnt_q == '0) begin
          state_d = ST_WAITLOCK;
`ifdef CLKSW_TIMEOUT_EN
          cnt_d   = LD_LOCK_TO;
`else
          cnt_d   = '0;
`endif
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_WAITLOCK: begin
        if (locked_s) begin
          state_d = ST_SETTLE;
          cnt_d   = LD_SETTLE1;
        end
`ifdef CLKSW_TIMEOUT_EN
        else if (cnt_q == '0) begin
          lock_err_d = 1'b1;
          state_d    = ST_PLLRST;
          cnt_d      = LD_PLLRST;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
`endif
      end
      ST_SETTLE: begin
        if (!locked_s) begin
          cnt_d = LD_SETTLE;
        end else if (cnt_q == '0) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_RUN: begin
        // Loss of lock re-runs the sequence with the current select.
        if (!locked_s || (req_valid && (req_q != mux_sel_q))) begin
          state_d = ST_QUIESCE;
          cnt_d   = LD_QUIESCE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Controller state registers; reset aborts any sequence in progress.
  always_ff @(posedge src_clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      mux_sel_q  <= '0;
      req_q      <= '0;
`ifdef CLKSW_TIMEOUT_EN
      lock_err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mux_sel_q  <= mux_sel_d;
      req_q      <= req_d;
`ifdef CLKSW_TIMEOUT_EN
      lock_err_q <= lock_err_d;
`endif
    end
  end

  // Outputs decode directly from state so reset takes effect immediately.
  assign mux_sel   = mux_sel_q;
  assign pll_rst   = (state_q == ST_IDLE) || (state_q == ST_PLLRST);
  assign sys_rst_n = (state_q == ST_RUN);
  assign busy      = (state_q != ST_RUN);
`ifdef CLKSW_TIMEOUT_EN
  assign lock_err  = lock_err_q;
`else
  assign lock_err  = 1'b0;
`endif

endmodule

// File: tb/tb_clock_switch_ctrl.sv
// Self-checking bench for clock_switch_ctrl with a cycle-level reference model
// that tracks the sequence phase and elapsed cycles in that phase.
module tb_clock_switch_ctrl;

  localparam int NUM_SRC = 3;
  localparam int SEL_W   = 2;
  localparam int QC      = 16;
  localparam int PRC     = 8;
  localparam int SC      = 256;
  localparam int LT      = 100;

  localparam int P_IDLE = 0, P_Q = 1, P_SW = 2, P_PR = 3, P_W = 4, P_S = 5, P_RUN = 6;

  logic             src_clock = 1'b0;
  logic             rst_n     = 1'b1;
  logic [SEL_W-1:0] req_sel   = '0;
  logic             locked    = 1'b0;
  logic [SEL_W-1:0] mux_sel;
  logic             pll_rst, sys_rst_n, busy, lock_err;

  int n_chk  = 0;
  int n_pass = 0;

  int m_ph, m_t, m_sel, m_req, m_err;
  bit m_l1, m_l2;

  clock_switch_ctrl #(
    .NUM_SRC     (NUM_SRC),
    .SEL_W       (SEL_W),
    .QUIESCE_CYC (QC),
    .PLL_RST_CYC (PRC),
    .SETTLE_CYC  (SC),
    .LOCK_TO_CYC (LT)
  ) dut (
    .src_clock (src_clock),
    .rst_n     (rst_n),
    .req_sel   (req_sel),
    .locked    (locked),
    .mux_sel   (mux_sel),
    .pll_rst   (pll_rst),
    .sys_rst_n (sys_rst_n),
    .busy      (busy),
    .lock_err  (lock_err)
  );

  always #5 src_clock = ~src_clock;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  function automatic void m_reset();
    m_ph = P_IDLE; m_t = 0; m_sel = 0; m_req = 0; m_err = 0;
    m_l1 = 1'b0; m_l2 = 1'b0;
  endfunction

  // One clock edge of the reference behaviour, from the values seen before the edge.
  function automatic void m_step();
    bit ls;
    int req;
    bit valid;
    ls = m_l2;
    req = m_req;
    valid = (req < NUM_SRC);
    case (m_ph)
      P_IDLE: begin m_ph = P_Q; m_t = 0; end
      P_Q: begin
        m_t++;
        if (m_t == QC) begin
          if (valid) m_sel = req;
          m_ph = P_SW;
        end
      end
      P_SW: begin m_ph = P_PR; m_t = 0; end
      P_PR: begin
        m_t++;
        if (m_t == PRC) begin m_ph = P_W; m_t = 0; end
      end
      P_W: begin
        if (ls) begin m_ph = P_S; m_t = 1; end
        else begin
          m_t++;
`ifdef CLKSW_TIMEOUT_EN
          if (m_t == LT + 1) begin m_err = 1; m_ph = P_PR; m_t = 0; end
`endif
        end
      end
      P_S: begin
        if (!ls) m_t = 0;
        else begin
          m_t++;
          if (m_t == SC) m_ph = P_RUN;
        end
      end
      default: begin
        if (!ls || (valid && req != m_sel)) begin m_ph = P_Q; m_t = 0; end
      end
    endcase
    m_l2 = m_l1;
    m_l1 = locked;
    m_req = int'(req_sel);
  endfunction

  task automatic check_outs();
    chk_eq("mux_sel", mux_sel, m_sel);
    chk_eq("pll_rst", pll_rst, (m_ph == P_IDLE) || (m_ph == P_PR));
    chk_eq("sys_rst_n", sys_rst_n, m_ph == P_RUN);
    chk_eq("busy", busy, m_ph != P_RUN);
    chk_eq("lock_err", lock_err, m_err);
  endtask

  task automatic tick();
    @(posedge src_clock);
    if (rst_n) m_step();
    else m_reset();
    #1;
    check_outs();
  endtask

  task automatic wait_run(input string tag, input int bound);
    for (int i = 0; i < bound && m_ph != P_RUN; i++) tick();
    chk_eq(tag, sys_rst_n, 1);
  endtask

  initial begin
    int n;
    #1 rst_n = 1'b0;
    #1 m_reset();
    check_outs();
    chk_eq("rst_pll", pll_rst, 1);
    repeat (3) tick();
    rst_n = 1'b1;

    // Power-up: lock arrives 30 cycles after release.
    repeat (30) tick();
    locked = 1'b1;
    n = 0;
    while (!sys_rst_n && n < 1000) begin tick(); n++; end
    chk_eq("pwrup_lat", n, SC + 2);
    chk_eq("pwrup_mux", mux_sel, 0);

    // Switch to source 1.
    repeat (5) tick();
    req_sel = 2'd1;
    n = 0;
    while (sys_rst_n && n < 20) begin tick(); n++; end
    chk_eq("sw_rst_lat", n, 2);
    n = 0;
    while (mux_sel != 2'd1 && n < 100) begin tick(); n++; end
    chk_eq("sw_mux_lat", n, QC);
    wait_run("sw_run", 2000);
    chk_eq("sw_mux", mux_sel, 1);

    // Lock glitch of 3 cycles while settling after a switch to source 2.
    req_sel = 2'd2;
    for (int i = 0; i < 2000 && !(m_ph == P_S && m_t >= 10 && m_t < 100); i++) tick();
    chk_eq("gl_settle", busy, 1);
    locked = 1'b0;
    repeat (3) tick();
    locked = 1'b1;
    n = 0;
    while (!sys_rst_n && n < 1000) begin tick(); n++; end
    chk_eq("gl_lat", n, SC + 2);

    // Out-of-range request is ignored.
    req_sel = 2'd3;
    repeat (60) tick();
    chk_eq("inv_busy", busy, 0);
    chk_eq("inv_mux", mux_sel, 2);

    // Lock lost and never returns.
    req_sel = 2'd2;
    locked = 1'b0;
    for (int i = 0; i < 200 && m_ph != P_W; i++) tick();
    chk_eq("to_wait", pll_rst, 0);
`ifdef CLKSW_TIMEOUT_EN
    n = 0;
    while (!lock_err && n < 1000) begin tick(); n++; end
    chk_eq("to_lat", n, LT + 1);
    chk_eq("to_repulse", pll_rst, 1);
`else
    repeat (LT + 50) tick();
    chk_eq("to_noerr", lock_err, 0);
    chk_eq("to_busy", busy, 1);
`endif
    locked = 1'b1;
    wait_run("to_run", 2000);

    // Reset pulse in the middle of a switch to source 1.
    req_sel = 2'd1;
    for (int i = 0; i < 200 && m_ph != P_PR; i++) tick();
    chk_eq("mid_pll", pll_rst, 1);
    chk_eq("mid_mux_pre", mux_sel, 1);
    #3 rst_n = 1'b0;
    #1 m_reset();
    check_outs();
    chk_eq("mid_mux", mux_sel, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    wait_run("mid_run", 2000);

    // Random requests and lock glitches.
    for (int e = 0; e < 30; e++) begin
      int len;
      req_sel = SEL_W'($urandom_range(0, 3));
      len = $urandom_range(20, 500);
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 99) < 1) begin
          locked = 1'b0;
          repeat ($urandom_range(1, 4)) tick();
          locked = 1'b1;
        end
        tick();
      end
    end
    wait_run("rnd_run", 3000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/clock_switch_ctrl.md
CLOCK_SWITCH_CTRL -- requirements
Module: clock_switch_ctrl

Interface
REQ-001 Parameter NUM_SRC, default 2: number of selectable clock sources, legal range 2..8.
REQ-002 Parameter SEL_W, default $clog2(NUM_SRC): width of all select fields.
REQ-003 Parameter QUIESCE_CYC, default 16: src_clock cycles downstream is held in reset before a switch.
REQ-004 Parameter PLL_RST_CYC, default 8: width in src_clock cycles of the pll_rst pulse.
REQ-005 Parameter SETTLE_CYC, default 256: src_clock cycles waited after lock before downstream is released.
REQ-006 Parameter LOCK_TO_CYC, default 65535: lock timeout in src_clock cycles.
REQ-007 One clock; reset is asynchronous and active-low.
REQ-008 src_clock  in  1  free-running oscillator clock; all logic runs on it.
REQ-009 rst_n  in  1  asynchronous active-low reset.
REQ-010 req_sel  in  SEL_W  requested source, for example the chip[0] model bit; may change at any time.
REQ-011 locked  in  1  PLL lock, asynchronous to src_clock.
REQ-012 mux_sel  out  SEL_W  select for the BUFGMUX tree.
REQ-013 pll_rst  out  1  active-high PLL reset.
REQ-014 sys_rst_n  out  1  active-low reset for the clk_dot4x domain.
REQ-015 busy  out  1  high whenever the state is not RUN.
REQ-016 lock_err  out  1  sticky lock-timeout flag.

Function
REQ-017 locked SHALL pass through a 2-flop synchronizer (locked_s) before use; this adds 2 cycles of latency.
REQ-018 The FSM SHALL have six states, IDLE, QUIESCE, SWITCH, PLLRST, WAITLOCK and SETTLE, plus RUN.
REQ-019 IDLE SHALL go to QUIESCE on the first cycle after reset.
REQ-020 RUN SHALL go to QUIESCE when the registered req_sel differs from mux_sel.
REQ-021 QUIESCE SHALL hold sys_rst_n=0 for QUIESCE_CYC cycles and then go to SWITCH.
REQ-022 SWITCH SHALL last 1 cycle: mux_sel<=req_sel is sampled here, then the FSM goes to PLLRST.
REQ-023 Any req_sel change after SWITCH SHALL be acted on only after the next RUN entry.
REQ-024 PLLRST SHALL hold pll_rst=1 for PLL_RST_CYC cycles and then go to WAITLOCK.
REQ-025 WAITLOCK SHALL go to SETTLE on locked_s=1.
REQ-026 SETTLE SHALL restart the settle counter whenever locked_s drops to 0, and go to RUN after SETTLE_CYC consecutive cycles with locked_s=1.
REQ-027 sys_rst_n SHALL rise on the first cycle in RUN.
REQ-028 In RUN, locked_s=0 SHALL cause a transition to QUIESCE (re-lock sequence with the same select).
REQ-029 A req_sel value >= NUM_SRC SHALL be ignored; mux_sel stays unchanged.
REQ-030 One shared down-counter SHALL be loaded on every state entry; its width is sized for the largest count parameter.

Reset
REQ-031 On rst_n=0 the outputs SHALL be: state=IDLE, mux_sel=0, pll_rst=1, sys_rst_n=0, busy=1, lock_err=0, synchronizer=0, counter=0.
REQ-032 Reset asserted mid-sequence SHALL abort the sequence immediately; no partial mux_sel update is kept.

Configuration
REQ-033 Macro CLKSW_TIMEOUT_EN selects the lock-timeout feature.
REQ-034 With CLKSW_TIMEOUT_EN defined: WAITLOCK exceeding LOCK_TO_CYC cycles sets lock_err and returns to PLLRST (retry, unbounded).
REQ-035 With CLKSW_TIMEOUT_EN defined: lock_err clears only on rst_n.
REQ-036 Without CLKSW_TIMEOUT_EN: WAITLOCK waits indefinitely, lock_err is tied to 0 and LOCK_TO_CYC is unused.

Structure
REQ-037 The state encoding enum and the default count constants SHALL live in a shared package, clkctl_pkg.
REQ-038 The synchronizer SHALL be a separate sub-module, sync2, reused for other asynchronous status inputs.
REQ-039 clock_switch_ctrl SHALL be instantiated beside clockgen; mux_sel drives the BUFGMUX S input.

Verification
REQ-040 Power-up: release rst_n, locked rises at cycle 30 -> pll_rst high for cycles 1..8 after QUIESCE, sys_rst_n rises 256+2 cycles after locked, mux_sel=0.
REQ-041 Switch: in RUN set req_sel=1 -> sys_rst_n low within 2 cycles, mux_sel=1 exactly 16 cycles later, full re-lock sequence follows, busy low only at the end.
REQ-042 Lock glitch: locked drops for 3 cycles during SETTLE -> settle count restarts and RUN is entered 256 cycles after recovery.
REQ-043 Timeout (macro on, LOCK_TO_CYC=100): locked held 0 -> lock_err=1 at WAITLOCK cycle 101, pll_rst re-pulses; same stimulus with macro off -> lock_err stays 0 and the FSM waits.
REQ-044 Invalid and mid-sequence: NUM_SRC=3, req_sel=3 -> no sequence, mux_sel unchanged; rst_n pulse during PLLRST -> all outputs return to reset values within the same cycle.
